// File: rtl/period_meter.sv
// period_meter: measures the period and high time of a slow square wave in
// system-clock cycles. sig_in is synchronised, rising edges are detected,
// and every completed input cycle produces a one-cycle valid pulse together
// with the registered period and high_time. A sticky timeout flags an input
// that stops toggling before the cycle counter saturates.
module period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } state_t;

    // Last count value before the counter would run out of range; a rise on
    // this cycle still reports a period of 2^CNT_W-1.
    localparam logic [CNT_W-1:0] CNT_SAT = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       hcnt;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    // Bring sig_in into the clk domain and keep one cycle of history for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            s_d  <= s;
        end
    end

    // Measurement FSM: arm on the first rise, then count each full input cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_FIRST;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                // Abort: partial counts are dropped, results and timeout are kept.
                state <= WAIT_FIRST;
                cnt   <= '0;
                hcnt  <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    WAIT_FIRST: begin
                        if (rise) begin
                            state <= MEASURE;
                            cnt   <= '0;
                            hcnt  <= CNT_ONE;
                            busy  <= 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            // The rise cycle closes this period and opens the next one.
                            period    <= cnt + CNT_ONE;
                            high_time <= hcnt;
                            valid     <= 1'b1;
                            timeout   <= 1'b0;
                            cnt       <= '0;
                            hcnt      <= CNT_ONE;
                        end else if (cnt == CNT_SAT) begin
                            state   <= WAIT_FIRST;
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            cnt     <= '0;
                            hcnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                            if (s) begin
                                hcnt <= hcnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= WAIT_FIRST;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: drives two period_meter instances (wide counter with a
// 2-flop synchroniser, and a 4-bit counter with a 3-flop synchroniser) from
// the same stimulus and compares every output on every cycle against an
// event-level reference model built from rise times and elapsed cycles.
module tb_period_meter;

    localparam int W_A  = 16;
    localparam int SS_A = 2;
    localparam int W_B  = 4;
    localparam int SS_B = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           sig_in;
    logic [W_A-1:0] period_a, high_time_a;
    logic           valid_a, timeout_a, busy_a;
    logic [W_B-1:0] period_b, high_time_b;
    logic           valid_b, timeout_b, busy_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    period_meter #(.CNT_W(W_A), .SYNC_STAGES(SS_A)) dut_a (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period(period_a), .high_time(high_time_a),
        .valid(valid_a), .timeout(timeout_a), .busy(busy_a)
    );

    period_meter #(.CNT_W(W_B), .SYNC_STAGES(SS_B)) dut_b (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period(period_b), .high_time(high_time_b),
        .valid(valid_b), .timeout(timeout_b), .busy(busy_b)
    );

    // Reference: remembers when the last counted rise of the synchronised
    // signal happened and how many high cycles have been seen since then.
    typedef struct {
        bit       armed;
        bit       tmo;
        bit       vld;
        int       per;
        int       hi;
        int       rise_edge;
        int       hacc;
        bit [4:0] hist;
    } model_t;

    model_t ma = '{default: 0};
    model_t mb = '{default: 0};

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, act, exp);
        end
    endtask

    // hist[0] holds sig_in sampled at the latest edge, so the synchronised
    // value seen by the FSM at this edge is the sample from ss edges ago.
    task automatic model_step(input model_t mi, input int w, input int ss,
                              input bit r, input bit e, input bit sg,
                              output model_t mo);
        bit s_now;
        bit s_prev;
        mo     = mi;
        mo.vld = 1'b0;
        if (!r) begin
            mo = '{default: 0};
        end else begin
            s_now   = mi.hist[ss-1];
            s_prev  = mi.hist[ss];
            mo.hist = {mi.hist[3:0], sg};
            if (!e) begin
                mo.armed = 1'b0;
            end else if (s_now && !s_prev) begin
                if (mi.armed) begin
                    mo.vld = 1'b1;
                    mo.per = cyc - mi.rise_edge;
                    mo.hi  = mi.hacc;
                    mo.tmo = 1'b0;
                end
                mo.armed     = 1'b1;
                mo.rise_edge = cyc;
                mo.hacc      = 1;
            end else if (mi.armed) begin
                if (cyc - mi.rise_edge == (1 << w) - 1) begin
                    mo.armed = 1'b0;
                    mo.tmo   = 1'b1;
                end else begin
                    mo.hacc = mi.hacc + int'(s_now);
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit sg);
        rst    = r;
        en     = e;
        sig_in = sg;
        @(posedge clk);
        cyc++;
        model_step(ma, W_A, SS_A, r, e, sg, ma);
        model_step(mb, W_B, SS_B, r, e, sg, mb);
        #1;
        check("a_valid",     int'(valid_a),     int'(ma.vld));
        check("a_busy",      int'(busy_a),      int'(ma.armed));
        check("a_timeout",   int'(timeout_a),   int'(ma.tmo));
        check("a_period",    int'(period_a),    ma.per);
        check("a_high_time", int'(high_time_a), ma.hi);
        check("b_valid",     int'(valid_b),     int'(mb.vld));
        check("b_busy",      int'(busy_b),      int'(mb.armed));
        check("b_timeout",   int'(timeout_b),   int'(mb.tmo));
        check("b_period",    int'(period_b),    mb.per);
        check("b_high_time", int'(high_time_b), mb.hi);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) step(1'b1, 1'b1, 1'b1);
            for (int i = 0; i < lo; i++) step(1'b1, 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [2:0] div;
        int hi, lo;

        // Reset held while the input toggles, then released with the input quiet.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);

        // Steady 50% wave, then duty variation and the fastest legal wave.
        wave(8, 8, 6);
        wave(3, 10, 6);
        wave(1, 1, 10);

        // Period of exactly 15 on the 4-bit instance: rise lands on the saturation cycle.
        wave(5, 10, 4);

        // Input stalls: the 4-bit instance times out, then a 6-cycle wave clears it.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
        wave(3, 3, 5);

        // Enable dropped for 3 cycles across a rise, then normal measurement resumes.
        wave(5, 5, 3);
        for (int i = 0; i < 10; i++) step(1'b1, !(i >= 1 && i <= 3), i < 5);
        wave(5, 5, 4);

        // Loopback from a 3-bit divider: led is the counter MSB.
        div = '0;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 1'b1, div[2]);
            div = div + 3'd1;
        end

        // Random waves with occasional enable drops and one mid-run reset.
        for (int p = 0; p < 300; p++) begin
            hi = $urandom_range(1, 20);
            lo = $urandom_range(1, 20);
            if (p == 150) begin
                step(1'b0, 1'b1, 1'b1);
                step(1'b0, 1'b1, 1'b0);
            end
            for (int i = 0; i < hi; i++) step(1'b1, ($urandom_range(0, 15) != 0), 1'b1);
            for (int i = 0; i < lo; i++) step(1'b1, ($urandom_range(0, 15) != 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
Measures an incoming slow square wave in system-clock cycles, such as the LED or divided-clock output of the team's clock divider. It synchronises the input and detects rising edges. For each completed cycle of the input it reports the period and the high time. It is the consumer end of the divider: the bench and board use it to confirm divide ratios and duty cycle.

Parameters:
CNT_W, 16, width of the period, high-time and internal cycle counters
SYNC_STAGES, 2, number of flip-flops in the input synchroniser (legal range 2 to 4)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  measurement enable; low aborts measurement and returns to WAIT_FIRST
sig_in  input  1  signal under measurement; asynchronous to clk
period  output  CNT_W  clk cycles between the last two qualified rising edges of sig_in
high_time  output  CNT_W  clk cycles the synchronised sig_in was high within that period
valid  output  1  one-cycle pulse; period and high_time updated this cycle
timeout  output  1  sticky flag; no edge arrived within 2^CNT_W-1 cycles
busy  output  1  high while in MEASURE

Behaviour:
- Reset is asynchronous and active-low on rst (rst=0 resets). While in reset and on release:
  - period=0, high_time=0, valid=0, timeout=0, busy=0
  - synchroniser flops=0, edge-history flop=0
  - cnt=0, hcnt=0, state=WAIT_FIRST
- Synchroniser: sig_in passes through a SYNC_STAGES flop chain to give s.
- Edge detection:
  - s_d is s delayed by one cycle.
  - rise = s & ~s_d.
  - Total latency from a sig_in transition to rise is SYNC_STAGES+1 clk edges.
- State WAIT_FIRST:
  - cnt and hcnt hold.
  - On rise with en=1: cnt<=0, hcnt<=1, go to MEASURE.
- State MEASURE, every cycle without rise:
  - cnt<=cnt+1.
  - hcnt<=hcnt+1 if s=1.
- State MEASURE, on rise:
  - period<=cnt+1 and high_time<=hcnt, both registered.
  - valid<=1 for exactly one cycle, the cycle after rise.
  - timeout<=0.
  - cnt<=0, hcnt<=1, stay in MEASURE. Back-to-back periods are measured with no gap.
- Counter saturation in MEASURE:
  - If cnt reaches 2^CNT_W-2 without a rise, the next cycle sets timeout<=1 and returns to WAIT_FIRST.
  - No valid pulse is produced; period and high_time hold their old values.
  - hcnt can never exceed cnt+1, so it cannot wrap.
- Enable:
  - en=0 in any state: next state WAIT_FIRST, cnt<=0, hcnt<=0, no valid pulse.
  - period, high_time and timeout hold.
  - A rise in the same cycle as en=0 is ignored.
- Simultaneous rise and saturation cycle: the rise wins; the period is reported as 2^CNT_W-1 and timeout is not set.
- busy=1 exactly when state=MEASURE (registered).
- Outputs are stable between valid pulses.
- Asserting reset mid-measurement discards the partial count. After release, the first rise only arms the block; the first valid follows the second rise.
- Glitches on sig_in shorter than one clk period may be missed. Any pulse that reaches s is a legal edge; there is no debounce.

Test Plan:
- Reset: drive rst=0 with sig_in toggling -> all outputs 0, busy=0; release rst and hold sig_in=0 -> no valid pulse ever.
- Steady 50% wave: en=1, sig_in high 8 / low 8 cycles, synchronous to clk -> first valid after the second rise, then every 16 cycles; period=16, high_time=8, busy=1.
- Duty variation: sig_in high 3 / low 10 cycles -> each valid reports period=13, high_time=3. Change to high 1 / low 1 -> period=2, high_time=1 on consecutive measurements with no missed pulse.
- Timeout: CNT_W=4, one rise then sig_in held low -> after 15 cycles in MEASURE, timeout=1, busy=0, period unchanged. A following 6-cycle wave -> timeout cleared on the first new valid, period=6.
- Enable abort: mid-period deassert en for 3 cycles across a rise -> no valid in that window. After en=1, the first rise re-arms and the next rise gives the correct period.
- Divider loopback: connect the 3-bit divider's led output to sig_in -> period equals the divider's nominal led period on every valid, and high_time is half of it.
